encdec_modq_reduce: RTL and testbench

ENCDEC_MODQ_REDUCE -- requirements
Module: encdec_modq_reduce

---
 rtl/encdec_modq_reduce.sv | 106 ++++++++++
 tb/tb_encdec_modq_reduce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encdec_modq_reduce.sv
// Barrett reduction of a 30-bit product mod Q: 3-stage valid/ready pipeline.
// Define ENCDEC_MODQ_RANGE_CHK_EN to add the sticky err input range check.
module encdec_modq_reduce #(
    parameter int Q         = 7681,
    parameter int BARRETT_M = 139791,
    parameter int N_COEF    = 256
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [29:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [12:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
    ,
    output logic        err
`endif
);

    localparam logic [31:0] QV    = 32'(Q);
    localparam logic [47:0] MV    = 48'(BARRETT_M);
    localparam logic [7:0]  LASTC = 8'(N_COEF - 1);

    logic        en;
    logic        v1;
    logic        v2;
    logic        v3;
    logic [29:0] x1;
    logic [47:0] p1;
    logic [31:0] t1;
    logic [31:0] tq;
    logic [31:0] r2;
    logic [31:0] d1;
    logic [12:0] red;
    logic [7:0]  cnt;
    logic        xfer;

    // Bubbles travel with the data; the whole pipe stalls only when S3 is full
    assign en        = dout_ready | ~v3;
    assign din_ready = en;
    assign xfer      = v3 & dout_ready;

    // Quotient estimate undershoots by at most 2, so r lands in [0, 3Q)
    assign p1 = {18'd0, x1} * MV;
    assign t1 = 32'(p1 >> 30);
    assign tq = t1 * QV;

    always_ff @(posedge ap_clk) begin
        if (en) begin
            x1 <= din;
            r2 <= {2'b00, x1} - tq;
        end
    end

    always_comb begin
        d1 = r2;
        if (d1 >= QV)
            d1 = d1 - QV;
        if (d1 >= QV)
            d1 = d1 - QV;
        red = 13'(d1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            dout <= '0;
        end else if (en) begin
            v1   <= din_valid;
            v2   <= v1;
            v3   <= v2;
            dout <= red;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else if (xfer) begin
            if (cnt == LASTC)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
        end
    end

    assign dout_valid = v3;
    assign dout_last  = v3 & (cnt == LASTC);

`ifdef ENCDEC_MODQ_RANGE_CHK_EN
    localparam logic [29:0] RMAX = 30'((Q - 1) * (Q - 1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            err <= 1'b0;
        else if (din_valid && en && (din > RMAX))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_encdec_modq_reduce.sv
// Self-checking bench for encdec_modq_reduce: directed tables plus a
// randomized stream scored against plain din % 7681 arithmetic.
module tb_encdec_modq_reduce;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [29:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [12:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
    logic        err;
`endif

    encdec_modq_reduce dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
        ,
        .err        (err)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [29:0] din;
        logic [12:0] exp;
    } vec_t;

    int          nvec = 0;
    int          nfail = 0;
    logic [63:0] expq[$];
    int          outcnt = 0;
    int          nlast = 0;
    int          nacc = 0;
    logic        stall_q = 1'b0;
    logic [12:0] hold_d = '0;
    logic        hold_l = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: inputs modelled as din % 7681, outputs in order, framing by count
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            expq.delete();
            outcnt = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_dout", dout, hold_d);
                chk("hold_last", dout_last, hold_l);
            end
            if (dout_valid) begin
                if (expq.size() == 0) begin
                    chk("stale_out", dout_valid, 0);
                end else begin
                    chk("dout", dout, expq[0]);
                    if (dout_ready) begin
                        chk("dout_last", dout_last, outcnt == 255);
                        if (dout_last)
                            nlast++;
                        void'(expq.pop_front());
                        outcnt = (outcnt + 1) % 256;
                    end
                end
            end
            if (din_valid && din_ready) begin
                expq.push_back(64'(din) % 64'd7681);
                nacc++;
            end
            stall_q = dout_valid && !dout_ready;
            hold_d = dout;
            hold_l = dout_last;
        end
    end

    task automatic send(input logic [29:0] v);
        din = v;
        din_valid = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge ap_clk);
            if (din_ready)
                break;
        end
        chk("send_ready", din_ready, 1);
        @(posedge ap_clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        din_valid = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge ap_clk);
            if (expq.size() == 0 && !dout_valid)
                break;
        end
        chk("drain_empty", expq.size(), 0);
        chk("drain_idle", dout_valid, 0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[5];
        logic [29:0] bp[3];
        int lbase;
        int abase;

        tab[0] = '{30'd0, 13'd0};
        tab[1] = '{30'd7680, 13'd7680};
        tab[2] = '{30'd7681, 13'd0};
        tab[3] = '{30'd58982400, 13'd1};
        tab[4] = '{30'd1073741823, 13'd7152};

        #3;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_dout", dout, 0);
        chk("rst_dout_last", dout_last, 0);
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
        chk("rst_err", err, 0);
`endif
        @(negedge ap_clk);
        @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Streamed values: each one surfaces exactly 3 cycles after acceptance
        dout_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            if (j < 5) begin
                din = tab[j].din;
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            @(negedge ap_clk);
            if (j >= 3 && j < 8) begin
                chk("basic_valid", dout_valid, 1);
                chk("basic_dout", dout, tab[j-3].exp);
            end else begin
                chk("basic_idle", dout_valid, 0);
            end
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
            chk("err_level", err, j >= 5);
`endif
            @(posedge ap_clk);
            #1;
        end

        // Backpressure with three items in flight
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bp[i] = 30'($urandom);
            send(bp[i]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            chk("bp_din_ready", din_ready, 0);
            chk("bp_valid", dout_valid, 1);
            chk("bp_dout", dout, 64'(bp[0]) % 64'd7681);
            @(posedge ap_clk);
            #1;
        end
        drain();

        // Reset with two items in flight
        send(30'd123456789);
        send(30'd987654);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_ready", din_ready, 1);
        chk("mid_rst_last", dout_last, 0);
        chk("mid_rst_dout", dout, 0);
`ifdef ENCDEC_MODQ_RANGE_CHK_EN
        chk("mid_rst_err", err, 0);
`endif
        @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            chk("post_rst_idle", dout_valid, 0);
        end
        @(posedge ap_clk);
        #1;

        // Two polynomials back to back
        lbase = nlast;
        for (int i = 0; i < 512; i++)
            send(30'($urandom));
        drain();
        chk("frame_lasts", nlast - lbase, 2);
        chk("frame_cnt", dut.cnt, 0);

        // Random valid/ready traffic
        abase = nacc;
        for (int c = 0; c < 60000 && (nacc - abase) < 20000; c++) begin
            din = 30'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            @(posedge ap_clk);
            #1;
        end
        chk("rand_accepts", (nacc - abase) >= 20000, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
